pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline-stage register, the next generation of the fixed per-field IF/ID/ID/EX/EX/MEM latches. It carries one WIDTH-bit packed payload between two stages with a valid/ready handshake and an optional two-entry skid. It supports a flush that inserts a bubble while preserving a configurable set of payload bits, such as a PC field needed for EPC. Every stage boundary in the 5-stage core instantiates it.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- SKID, 0: 0 = single register, combinational ready. 1 = main plus skid entry, registered ready.
- KEEP_MASK, {WIDTH{1'b0}}: bit = 1 means the payload bit holds its value on flush. Bit = 0 means it clears to 0.
- clk  in  1  sole clock. All state changes on rising edge.
- reset  in  1  synchronous, active-high. Clock and reset are fixed as one clock, synchronous active-high reset.
- flush  in  1  synchronous bubble insert (hazard clear / interrupt clear, ORed upstream).
- in_valid  in  1  upstream beat present.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  stage accepts beat this cycle.
- out_valid  out  1  downstream beat present.
- out_data  out  WIDTH  payload of the oldest held beat.
- out_ready  in  1  downstream accepts (low = stall).
- occupancy  out  2  beats held, 0..2.

## Operation
- In-fire = in_valid & in_ready. Out-fire = out_valid & out_ready. Both are sampled at the rising edge of clk.
- Priority per edge: reset > flush > handshake.
- Reset sets:
  - out_valid = 0, out_data = 0, skid = 0, occupancy = 0, state EMPTY.
  - in_ready = 1 from the first cycle after reset.
- Flush:
  - State goes to EMPTY, out_valid = 0, occupancy = 0.
  - main ← main & KEEP_MASK. Skid payload cleared.
  - in_ready is forced 0 while flush is high, so no beat is accepted and no beat is lost silently.
  - Out-fire in a flush cycle is still honoured by the downstream stage; the stage itself does not care.
- SKID=0:
  - in_ready = (!out_valid | out_ready) & !flush.
  - On in-fire: main ← in_data, out_valid ← 1.
  - On out-fire without in-fire: out_valid ← 0, and main holds its value.
- SKID=1, three-state FSM:
  - EMPTY: in_ready = 1. In-fire: main ← in, go to HALF.
  - HALF:
    - in_ready = 1.
    - in-fire & out-fire: main ← in, stay HALF.
    - in-fire & !out-fire: skid ← in, go to FULL.
    - out-fire only: go to EMPTY.
  - FULL: in_ready = 0. Out-fire: main ← skid, go to HALF.
  - In SKID=1, in_ready is a registered state decode (state != FULL), ANDed only with !flush.
- out_valid = (state != EMPTY). out_data is always main. occupancy is 0, 1 or 2 per state (max 1 when SKID=0).
- Beats leave in exactly the order accepted. There is no duplication and no drop except on flush.
- While out_valid = 0, out_data is stable: last value, or the masked value after a flush. Downstream decode of a bubble therefore sees IR = 0 when the IR bits are not in KEEP_MASK.

## Timing
- Latency from in-fire to out_valid: 1 cycle. Throughput: 1 beat/cycle when out_ready stays high.
- Stall: holding out_ready low freezes out_data and out_valid.
  - SKID=0: in_ready drops in the same cycle.
  - SKID=1: in_ready drops the cycle after the skid fills. A beat offered in the stall-onset cycle is absorbed.
- Boundary rules:
  - Simultaneous in-fire and out-fire in HALF keeps occupancy at 1.
  - Flush together with in_valid: the beat is not accepted. Upstream holds it (in_ready = 0).
  - Reset during FULL: both entries are dropped and the next cycle shows EMPTY.
  - Flush while in FULL discards both beats. The kept bits come from main, not skid.

## Structure
- Shared package pipe_pkg holds:
  - the state typedef (EMPTY, HALF, FULL, 2-bit encoding 0/1/2);
  - default WIDTH constants per stage boundary (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W);
  - field-offset constants used to build each stage's KEEP_MASK.
- One sub-module, pipe_skid_slot: the skid entry with load/clear. It is generated only when SKID=1.

## Test plan
All scenarios use WIDTH=32, KEEP_MASK=32'hFFFF_0000.
- Reset: in_valid=1 during reset → out_valid=0, out_data=0, occupancy=0. First accept occurs on the first post-reset edge.
- Streaming, SKID=0 and SKID=1, out_ready=1: inputs 1,2,3,4 on consecutive cycles → outputs 1,2,3,4, each one cycle later, with no gaps.
- Stall, SKID=1: accept 0xA, 0xB; out_ready=0 for 3 cycles, then 1. Required:
  - in_ready is 0 while FULL;
  - occupancy=2;
  - outputs are 0xA then 0xB with no loss.
- Flush keep: main=0x1234_5678 valid; flush=1 → out_valid=0, out_data=0x1234_0000.
- Flush during FULL with in_valid=1, in_data=0xC: in_ready=0 in that cycle. Required:
  - next cycle occupancy=0;
  - 0xC is accepted on the following edge and appears one cycle later.
- Random valid/ready/flush for 10k cycles against a queue model. Required:
  - order and payload match;
  - occupancy never exceeds 1 + SKID.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers of the 5-stage core:
// handshake state encoding, per-boundary payload widths and field offsets.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int unsigned MAX_W = 128;
    typedef logic [MAX_W-1:0] field_mask_t;

    localparam int unsigned PC_W = 32;
    localparam int unsigned IR_W = 32;

    localparam int unsigned IF_ID_W  = 64;
    localparam int unsigned ID_EX_W  = 128;
    localparam int unsigned EX_MEM_W = 112;
    localparam int unsigned MEM_WB_W = 72;

    // The PC sits in the top bits of each boundary so EPC survives a flush
    localparam int unsigned IF_ID_IR_LSB  = 0;
    localparam int unsigned IF_ID_PC_LSB  = IF_ID_W  - PC_W;
    localparam int unsigned ID_EX_PC_LSB  = ID_EX_W  - PC_W;
    localparam int unsigned EX_MEM_PC_LSB = EX_MEM_W - PC_W;

    function automatic field_mask_t field_mask(input int unsigned lsb, input int unsigned width);
        field_mask_t ones;
        ones = '1;
        return (ones >> (MAX_W - width)) << lsb;
    endfunction

    localparam field_mask_t IF_ID_KEEP  = field_mask(IF_ID_PC_LSB, PC_W);
    localparam field_mask_t ID_EX_KEEP  = field_mask(ID_EX_PC_LSB, PC_W);
    localparam field_mask_t EX_MEM_KEEP = field_mask(EX_MEM_PC_LSB, PC_W);

endpackage

// File: rtl/pipe_skid_slot.sv
// Second payload entry of a skid-buffered stage; loads on demand, clears on
// reset or flush.
module pipe_skid_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with optional skid entry and a flush
// that keeps KEEP_MASK bits of the held payload.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      SKID      = 0,
    parameter logic [WIDTH-1:0] KEEP_MASK = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    pipe_state_t      state_p1, state_nxt;
    logic [WIDTH-1:0] data_p1;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire, out_fire;
    logic             main_ld, main_from_skid;

    assign out_valid = (state_p1 != EMPTY);
    assign out_data  = data_p1;
    assign occupancy = state_p1;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic skid_ld;
            // Ready comes straight from the state register, not from out_ready
            assign in_ready = (state_p1 != FULL) & ~flush;
            assign skid_ld  = (state_p1 == HALF) & in_fire & ~out_fire;

            pipe_skid_slot #(.WIDTH(WIDTH)) u_skid (
                .clk   (clk),
                .reset (reset),
                .load  (skid_ld),
                .clear (flush),
                .d     (in_data),
                .q     (skid_data)
            );
        end else begin : g_noskid
            assign in_ready  = (~out_valid | out_ready) & ~flush;
            assign skid_data = '0;
        end
    endgenerate

    always_comb begin
        state_nxt      = state_p1;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        case (state_p1)
            EMPTY: begin
                if (in_fire) begin
                    main_ld   = 1'b1;
                    state_nxt = HALF;
                end
            end
            HALF: begin
                if (in_fire && (out_fire || SKID == 0)) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    state_nxt = FULL;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = HALF;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
        end
    end

    // Stage boundary: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1 <= EMPTY;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    // Stage boundary: main payload register; a bubble keeps only the masked bits
    always_ff @(posedge clk) begin
        if (reset) begin
            data_p1 <= '0;
        end else if (flush) begin
            data_p1 <= data_p1 & KEEP_MASK;
        end else if (main_ld) begin
            data_p1 <= main_from_skid ? skid_data : in_data;
        end
    end

endmodule
